register_file: RTL and testbench

- 32 x 32-bit register file with two read ports and one write port.
- Sits directly downstream of decoder_5_32: the decoder turns the write address into a one-hot row-enable bus, and this block consumes that bus to load one register.
- Sits in the datapath between instruction decode (read addresses) and write-back (write address/data).
- Synchronous write, registered reads (1-cycle latency), write-to-read bypass, register 0 hardwired to zero.

---
 rtl/register_file_pkg.sv | 14 +
 rtl/register_file_decoder_5_32.sv | 13 +
 rtl/register_file.sv | 82 ++++++++
 tb/tb_register_file.sv | 129 ++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared datapath types and constants for the register file, decode and write-back stages.
package register_file_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int ZERO_REG   = 0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     word_t;

   function automatic logic is_zero_reg(input reg_addr_t a);
      return a == reg_addr_t'(ZERO_REG);
   endfunction
endpackage

// File: rtl/register_file_decoder_5_32.sv
// Binary-to-one-hot address decoder; drives the row-enable bus of the register file.
module decoder_5_32 #(
   parameter int OUTPUTS = 32,
   parameter int ADDR    = 5
) (
   input  logic [ADDR-1:0]    i_addr,
   output logic [OUTPUTS-1:0] o_line
);
   always_comb begin
      o_line         = '0;
      o_line[i_addr] = 1'b1;
   end
endmodule

// File: rtl/register_file.sv
// 32x32 register file: two registered read ports, one write port, write-first bypass,
// register 0 hardwired to zero.
module register_file
   import register_file_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int ADDR  = REG_ADDR_W,
   parameter int REGS  = NUM_REGS
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [ADDR-1:0]  Ard1,
   input  logic [ADDR-1:0]  Ard2,
   input  logic [ADDR-1:0]  Awr,
   input  logic [WIDTH-1:0] Din,
   input  logic             WrEn,
   output logic [WIDTH-1:0] Dout1,
   output logic [WIDTH-1:0] Dout2
);
   localparam logic [ADDR-1:0] ZERO_ADDR = ADDR'(ZERO_REG);

   if (REGS != 2**ADDR) begin : g_bad_params
      $error("register_file: REGS must equal 2**ADDR");
   end

   logic [WIDTH-1:0] r_regs [REGS];
   logic [WIDTH-1:0] r_dout1;
   logic [WIDTH-1:0] r_dout2;
   logic [REGS-1:0]  w_wr_line;
   logic             w_wr_ok;
   logic [WIDTH-1:0] w_rd1;
   logic [WIDTH-1:0] w_rd2;

   decoder_5_32 #(
      .OUTPUTS (REGS),
      .ADDR    (ADDR)
   ) u_decoder (
      .i_addr (Awr),
      .o_line (w_wr_line)
   );

   assign w_wr_ok = WrEn && (Awr != ZERO_ADDR);

   // Address 0 wins over the bypass so the zero register can never leak write data.
   always_comb begin
      w_rd1 = r_regs[Ard1];
      if (Ard1 == ZERO_ADDR)
         w_rd1 = '0;
      else if (w_wr_ok && (Awr == Ard1))
         w_rd1 = Din;

      w_rd2 = r_regs[Ard2];
      if (Ard2 == ZERO_ADDR)
         w_rd2 = '0;
      else if (w_wr_ok && (Awr == Ard2))
         w_rd2 = Din;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < REGS; i++)
            r_regs[i] <= '0;
      end else begin
         for (int i = 1; i < REGS; i++)
            if (WrEn && w_wr_line[i])
               r_regs[i] <= Din;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_dout1 <= '0;
         r_dout2 <= '0;
      end else begin
         r_dout1 <= w_rd1;
         r_dout2 <= w_rd2;
      end
   end

   assign Dout1 = r_dout1;
   assign Dout2 = r_dout2;
endmodule

// File: tb/tb_register_file.sv
// Randomised and directed bench for register_file against an array-based reference model.
module tb_register_file;
   import register_file_pkg::*;

   logic      Clk = 1'b0;
   logic      Reset;
   reg_addr_t Ard1, Ard2, Awr;
   word_t     Din;
   logic      WrEn;
   word_t     Dout1, Dout2;

   word_t m_regs [NUM_REGS];
   int    n_checks = 0;
   int    n_errors = 0;

   register_file u_dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Ard1  (Ard1),
      .Ard2  (Ard2),
      .Awr   (Awr),
      .Din   (Din),
      .WrEn  (WrEn),
      .Dout1 (Dout1),
      .Dout2 (Dout2)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input word_t got, input word_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic word_t model_read(input reg_addr_t a, input bit wr,
                                        input reg_addr_t aw, input word_t d);
      if (a == 0) return '0;
      if (wr && aw == a) return d;
      return m_regs[a];
   endfunction

   task automatic step(input string tag, input bit wr, input reg_addr_t aw, input word_t d,
                       input reg_addr_t a1, input reg_addr_t a2);
      word_t e1, e2;
      @(negedge Clk);
      WrEn = wr; Awr = aw; Din = d; Ard1 = a1; Ard2 = a2;
      e1 = model_read(a1, wr, aw, d);
      e2 = model_read(a2, wr, aw, d);
      if (wr && aw != 0) m_regs[aw] = d;
      @(posedge Clk);
      #1;
      chk({tag, ".dout1"}, Dout1, e1);
      chk({tag, ".dout2"}, Dout2, e2);
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      Reset = 1'b1; WrEn = 0; Awr = 0; Din = 0; Ard1 = 0; Ard2 = 0;
      model_clear();
      repeat (2) @(posedge Clk);
      #1;
      chk("reset.dout1", Dout1, '0);
      chk("reset.dout2", Dout2, '0);
      @(negedge Clk);
      Reset = 1'b0;

      step("basic.wr", 1, 5'd3, 32'h12345678, 5'd0, 5'd0);
      step("basic.rd", 0, 5'd0, 32'h0, 5'd3, 5'd3);

      for (int a = 1; a < NUM_REGS; a++)
         step("sweep.wr", 1, reg_addr_t'(a), word_t'(a) * 32'h01010101, reg_addr_t'(a - 1), 5'd0);
      for (int a = 1; a < NUM_REGS; a++)
         step("sweep.rd", 0, 5'd0, 32'h0, reg_addr_t'(a), reg_addr_t'(NUM_REGS - a));

      step("zero.wr", 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      step("zero.rd", 0, 5'd0, 32'h0, 5'd0, 5'd0);

      step("byp.pre", 1, 5'd7, 32'hAAAA0000, 5'd0, 5'd0);
      step("byp.same", 1, 5'd7, 32'h0000BBBB, 5'd7, 5'd8);
      step("byp.next", 0, 5'd0, 32'h0, 5'd7, 5'd7);

      step("wren.pre", 1, 5'd9, 32'h11111111, 5'd0, 5'd0);
      step("wren.low", 0, 5'd9, 32'h55555555, 5'd9, 5'd9);
      step("wren.rd", 0, 5'd0, 32'h0, 5'd9, 5'd9);

      step("dual.wr", 1, 5'd12, 32'hCAFEF00D, 5'd0, 5'd0);
      step("dual.rd", 0, 5'd0, 32'h0, 5'd12, 5'd12);
      step("hot.wr", 1, 5'd31, 32'h31313131, 5'd30, 5'd0);
      step("hot.rd", 0, 5'd0, 32'h0, 5'd31, 5'd30);

      step("rst.wr", 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      step("rst.rd", 0, 5'd0, 32'h0, 5'd5, 5'd5);
      #2;
      Reset = 1'b1;
      WrEn = 1; Awr = 5'd6; Din = 32'h66666666;
      #1;
      chk("rst.async1", Dout1, '0);
      chk("rst.async2", Dout2, '0);
      model_clear();
      @(negedge Clk);
      Reset = 1'b0; WrEn = 0;
      #1;
      chk("rst.hold1", Dout1, '0);
      step("rst.after", 0, 5'd0, 32'h0, 5'd5, 5'd6);

      for (int n = 0; n < 400; n++) begin
         reg_addr_t aw, a1, a2;
         aw = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
         a1 = ($urandom_range(0, 3) == 0) ? aw : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
         a2 = ($urandom_range(0, 3) == 0) ? aw : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
         step("rand", bit'($urandom_range(0, 1)), aw, word_t'($urandom), a1, a2);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
